// File: rtl/i2c_pkg.sv
// Shared I2C definitions: FSM states, R/W encoding and byte size.
// Used by the target receiver and by the master transmitter.
package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        DATA,
        DATA_ACK,
        IGNORE
    } i2c_state_t;

    localparam logic       I2C_RW_WRITE      = 1'b0;
    localparam logic [3:0] I2C_BITS_PER_BYTE = 4'd8;

endpackage

// File: rtl/i2c_bus_sync.sv
// SCL/SDA synchronizer with registered edge and START/STOP flags.
// Ports: i_scl/i_sda raw lines; o_sda sample aligned with the flags;
// o_scl_rise/o_scl_fall/o_start/o_stop one-cycle flags.
module i2c_bus_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_scl,
    input  logic i_sda,
    output logic o_sda,
    output logic o_scl_rise,
    output logic o_scl_fall,
    output logic o_start,
    output logic o_stop
);

    logic [SYNC_STAGES-1:0] r_scl_sync;
    logic [SYNC_STAGES-1:0] r_sda_sync;
    logic                   r_scl_prev;
    logic                   r_sda_prev;
    logic                   r_scl_rise;
    logic                   r_scl_fall;
    logic                   r_start;
    logic                   r_stop;
    logic                   w_scl;
    logic                   w_sda;

    assign w_scl = r_scl_sync[SYNC_STAGES-1];
    assign w_sda = r_sda_sync[SYNC_STAGES-1];

    // Idle bus is high, so the chain resets to 1 to avoid false edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
            r_scl_prev <= 1'b1;
            r_sda_prev <= 1'b1;
            r_scl_rise <= 1'b0;
            r_scl_fall <= 1'b0;
            r_start    <= 1'b0;
            r_stop     <= 1'b0;
        end else begin
            r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], i_scl};
            r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], i_sda};
            r_scl_prev <= w_scl;
            r_sda_prev <= w_sda;
            r_scl_rise <= w_scl & ~r_scl_prev;
            r_scl_fall <= ~w_scl & r_scl_prev;
            r_start    <= w_scl & r_scl_prev & r_sda_prev & ~w_sda;
            r_stop     <= w_scl & r_scl_prev & ~r_sda_prev & w_sda;
        end
    end

    // r_sda_prev holds the SDA sample taken with the edge that set the flags.
    assign o_sda      = r_sda_prev;
    assign o_scl_rise = r_scl_rise;
    assign o_scl_fall = r_scl_fall;
    assign o_start    = r_start;
    assign o_stop     = r_stop;

endmodule

// File: rtl/i2c_slave_receiver.sv
// I2C target write receiver: address match, ACK drive, byte strobe.
// Ports: scl_in/sda_in raw bus, sda_oe open-drain pull, rx_data/rx_valid
// byte output, busy while addressed, start_det/stop_det pulses.
module i2c_slave_receiver
    import i2c_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR    = 7'h42,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       busy,
    output logic       start_det,
    output logic       stop_det
);

    logic       w_sda;
    logic       w_rise;
    logic       w_fall;
    logic       w_start;
    logic       w_stop;
    logic [7:0] w_shift_in;

    i2c_state_t r_state, w_state;
    logic [3:0] r_cnt, w_cnt;
    logic [7:0] r_shift, w_shift;
    logic       r_oe, w_oe;
    logic [7:0] r_rx_data, w_rx_data;
    logic       r_rx_valid, w_rx_valid;
    logic       r_busy, w_busy;
    logic       r_start_det, w_start_det;
    logic       r_stop_det, w_stop_det;

    i2c_bus_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_scl      (scl_in),
        .i_sda      (sda_in),
        .o_sda      (w_sda),
        .o_scl_rise (w_rise),
        .o_scl_fall (w_fall),
        .o_start    (w_start),
        .o_stop     (w_stop)
    );

    assign w_shift_in = {r_shift[6:0], w_sda};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_shift     <= '0;
            r_oe        <= 1'b0;
            r_rx_data   <= '0;
            r_rx_valid  <= 1'b0;
            r_busy      <= 1'b0;
            r_start_det <= 1'b0;
            r_stop_det  <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_cnt       <= w_cnt;
            r_shift     <= w_shift;
            r_oe        <= w_oe;
            r_rx_data   <= w_rx_data;
            r_rx_valid  <= w_rx_valid;
            r_busy      <= w_busy;
            r_start_det <= w_start_det;
            r_stop_det  <= w_stop_det;
        end
    end

    always_comb begin
        w_state     = r_state;
        w_cnt       = r_cnt;
        w_shift     = r_shift;
        w_oe        = r_oe;
        w_rx_data   = r_rx_data;
        w_rx_valid  = 1'b0;
        w_busy      = r_busy;
        w_start_det = 1'b0;
        w_stop_det  = 1'b0;
        if (w_stop) begin
            w_state    = IDLE;
            w_cnt      = '0;
            w_oe       = 1'b0;
            w_busy     = 1'b0;
            w_stop_det = 1'b1;
        end else if (w_start) begin
            w_state     = ADDR;
            w_cnt       = '0;
            w_shift     = '0;
            w_oe        = 1'b0;
            w_busy      = 1'b0;
            w_start_det = 1'b1;
        end else begin
            unique case (r_state)
                IDLE: ;
                ADDR: begin
                    if (w_rise) begin
                        w_shift = w_shift_in;
                        w_cnt   = r_cnt + 4'd1;
                        if (w_cnt == I2C_BITS_PER_BYTE) begin
                            if (w_shift_in[7:1] == DEV_ADDR &&
                                w_shift_in[0] == I2C_RW_WRITE) begin
                                w_state = ADDR_ACK;
                                w_busy  = 1'b1;
                            end else begin
                                w_state = IGNORE;
                            end
                        end
                    end
                end
                DATA: begin
                    if (w_rise) begin
                        w_shift = w_shift_in;
                        w_cnt   = r_cnt + 4'd1;
                        if (w_cnt == I2C_BITS_PER_BYTE) begin
                            w_rx_data  = w_shift_in;
                            w_rx_valid = 1'b1;
                            w_state    = DATA_ACK;
                        end
                    end
                end
                // First fall (8th) pulls SDA, second fall (9th) releases it.
                ADDR_ACK, DATA_ACK: begin
                    if (w_fall) begin
                        w_oe = ~r_oe;
                        if (r_oe) begin
                            w_state = DATA;
                            w_cnt   = '0;
                        end
                    end
                end
                IGNORE: w_oe = 1'b0;
                default: begin
                    w_state = IDLE;
                    w_oe    = 1'b0;
                end
            endcase
        end
    end

    assign sda_oe    = r_oe;
    assign rx_data   = r_rx_data;
    assign rx_valid  = r_rx_valid;
    assign busy      = r_busy;
    assign start_det = r_start_det;
    assign stop_det  = r_stop_det;

endmodule

// File: tb/tb_i2c_slave_receiver.sv
// Directed and random bench for i2c_slave_receiver.
// Bus master model drives SCL/SDA; a queue model predicts received bytes.
module tb_i2c_slave_receiver;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       m_scl = 1'b1;
    logic       m_sda = 1'b1;
    logic       sda_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy;
    logic       start_det;
    logic       stop_det;
    logic       sda_bus;

    int n_assert = 0;
    int n_fail   = 0;
    int n_start  = 0;
    int n_stop   = 0;
    int oe_seen  = 0;
    int busy_seen = 0;
    logic [7:0] got[$];
    logic [7:0] expq[$];

    assign sda_bus = m_sda & ~sda_oe;

    always #5 clk = ~clk;

    i2c_slave_receiver #(
        .DEV_ADDR    (7'h42),
        .SYNC_STAGES (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .scl_in    (m_scl),
        .sda_in    (sda_bus),
        .sda_oe    (sda_oe),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .busy      (busy),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    always @(negedge clk) begin
        if (rx_valid) got.push_back(rx_data);
        if (start_det) n_start++;
        if (stop_det) n_stop++;
        if (sda_oe) oe_seen++;
        if (busy) busy_seen++;
    end

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        got.delete();
        expq.delete();
        n_start = 0;
        n_stop = 0;
        oe_seen = 0;
        busy_seen = 0;
    endtask

    task automatic do_start();
        if (m_scl == 1'b0) begin
            wait_n(3);
            m_sda = 1'b1;
            wait_n(4);
            m_scl = 1'b1;
            wait_n(5);
        end
        m_sda = 1'b0;
        wait_n(5);
        m_scl = 1'b0;
    endtask

    task automatic do_stop();
        wait_n(3);
        m_sda = 1'b0;
        wait_n(4);
        m_scl = 1'b1;
        wait_n(5);
        m_sda = 1'b1;
        wait_n(6);
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            wait_n(3);
            m_sda = b[i];
            wait_n(4);
            m_scl = 1'b1;
            wait_n(6);
            m_scl = 1'b0;
        end
    endtask

    // Eight bits plus the ACK clock, with latency checks on the strobe and ACK.
    task automatic send_byte(input logic [7:0] b, input logic ack,
                             input logic is_data);
        for (int i = 7; i >= 0; i--) begin
            wait_n(3);
            m_sda = b[i];
            wait_n(4);
            m_scl = 1'b1;
            if (i == 0 && is_data) begin
                wait_n(3);
                chk("rxv_early", rx_valid, 0);
                wait_n(1);
                chk("rxv_lat", rx_valid, ack);
                if (ack) chk("rx_data_lat", rx_data, b);
                wait_n(2);
            end else begin
                wait_n(6);
            end
            m_scl = 1'b0;
        end
        wait_n(3);
        chk("oe_early", sda_oe, 0);
        m_sda = 1'b1;
        wait_n(1);
        chk("ack_rise", sda_oe, ack);
        wait_n(3);
        m_scl = 1'b1;
        wait_n(3);
        chk("ack_high", sda_oe, ack);
        chk("ack_bus", sda_bus, !ack);
        wait_n(3);
        m_scl = 1'b0;
        wait_n(3);
        chk("oe_hold", sda_oe, ack);
        wait_n(1);
        chk("oe_rel", sda_oe, 0);
    endtask

    task automatic cmp_queue(input string tag);
        chk({tag, "_cnt"}, got.size(), expq.size());
        for (int i = 0; i < got.size() && i < expq.size(); i++)
            chk({tag, "_byte"}, got[i], expq[i]);
    endtask

    initial begin
        logic [6:0] addr;
        logic       rw;
        logic       ack;
        logic [7:0] d;
        int         nb;

        wait_n(3);
        chk("rst_oe", sda_oe, 0);
        chk("rst_rx_data", rx_data, 0);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_start", start_det, 0);
        chk("rst_stop", stop_det, 0);
        rst_n = 1'b1;
        wait_n(5);

        // Basic write
        clear_mon();
        do_start();
        send_byte(8'h84, 1'b1, 1'b0);
        chk("basic_busy", busy, 1);
        expq.push_back(8'hA5);
        send_byte(8'hA5, 1'b1, 1'b1);
        do_stop();
        cmp_queue("basic_rx");
        chk("basic_start_cnt", n_start, 1);
        chk("basic_stop_cnt", n_stop, 1);
        chk("basic_busy_end", busy, 0);

        // Wrong address
        clear_mon();
        do_start();
        send_byte(8'h86, 1'b0, 1'b0);
        send_byte(8'h55, 1'b0, 1'b1);
        do_stop();
        cmp_queue("wrong_rx");
        chk("wrong_oe_seen", oe_seen, 0);
        chk("wrong_busy_seen", busy_seen, 0);

        // Read request
        clear_mon();
        do_start();
        send_byte(8'h85, 1'b0, 1'b0);
        send_byte(8'h3C, 1'b0, 1'b1);
        chk("read_busy", busy, 0);
        do_stop();
        cmp_queue("read_rx");
        chk("read_oe_seen", oe_seen, 0);
        chk("read_stop_cnt", n_stop, 1);

        // Multi-byte with repeated START
        clear_mon();
        do_start();
        send_byte(8'h84, 1'b1, 1'b0);
        send_byte(8'h01, 1'b1, 1'b1);
        send_byte(8'h02, 1'b1, 1'b1);
        do_start();
        send_byte(8'h84, 1'b1, 1'b0);
        chk("multi_busy", busy, 1);
        send_byte(8'hFF, 1'b1, 1'b1);
        chk("multi_busy2", busy, 1);
        do_stop();
        expq.push_back(8'h01);
        expq.push_back(8'h02);
        expq.push_back(8'hFF);
        cmp_queue("multi_rx");
        chk("multi_start_cnt", n_start, 2);
        chk("multi_stop_cnt", n_stop, 1);
        chk("multi_busy_end", busy, 0);
        chk("multi_last_data", rx_data, 8'hFF);

        // Partial byte abort
        clear_mon();
        do_start();
        send_byte(8'h84, 1'b1, 1'b0);
        send_bits(8'hB7, 5);
        do_stop();
        cmp_queue("abort_rx");
        chk("abort_oe", sda_oe, 0);
        chk("abort_busy", busy, 0);
        chk("abort_data_kept", rx_data, 8'hFF);

        // Reset in DATA_ACK while SDA is pulled
        clear_mon();
        do_start();
        send_byte(8'h84, 1'b1, 1'b0);
        send_bits(8'h9A, 8);
        wait_n(5);
        m_sda = 1'b1;
        chk("mid_pre_oe", sda_oe, 1);
        m_scl = 1'b1;
        wait_n(2);
        rst_n = 1'b0;
        #1;
        chk("mid_oe", sda_oe, 0);
        chk("mid_rx_data", rx_data, 0);
        chk("mid_rx_valid", rx_valid, 0);
        chk("mid_busy", busy, 0);
        chk("mid_start", start_det, 0);
        chk("mid_stop", stop_det, 0);
        wait_n(2);
        rst_n = 1'b1;
        clear_mon();
        wait_n(2);
        m_scl = 1'b0;
        send_byte(8'h3C, 1'b0, 1'b1);
        chk("mid_after_oe_seen", oe_seen, 0);
        chk("mid_after_busy", busy_seen, 0);
        do_stop();
        cmp_queue("mid_rx");

        // Random transactions against the byte-level model
        for (int t = 0; t < 8; t++) begin
            clear_mon();
            addr = ($urandom_range(0, 1) == 1) ? 7'h42
                                               : 7'($urandom_range(0, 127));
            rw = ($urandom_range(0, 3) == 0);
            nb = $urandom_range(1, 3);
            ack = (addr == 7'h42) && !rw;
            do_start();
            send_byte({addr, rw}, ack, 1'b0);
            for (int k = 0; k < nb; k++) begin
                d = 8'($urandom);
                if (ack) expq.push_back(d);
                send_byte(d, ack, 1'b1);
            end
            do_stop();
            cmp_queue("rand_rx");
            chk("rand_start_cnt", n_start, 1);
            chk("rand_stop_cnt", n_stop, 1);
            chk("rand_busy_end", busy, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
